// File: rtl/shift_issue_stage.sv
// Issue stage in front of barrelshifter32: decodes R-type shift ops into a/b/aluc
// operands and buffers them in a 2-entry FIFO with valid/ready on both sides.
module shift_issue_stage #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int TAGW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_funct,
  input  logic [WIDTH-1:0] in_rs,
  input  logic [WIDTH-1:0] in_rt,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sh_a,
  output logic [SHW-1:0]   sh_b,
  output logic [1:0]       sh_aluc,
  output logic [TAGW-1:0]  sh_tag,
  output logic             err_pulse,
  output logic [7:0]       err_cnt
);

  localparam int EW = WIDTH + SHW + 2 + TAGW;

  logic [1:0]      count_reg, count_next;
  logic            wr_ptr_reg, rd_ptr_reg;
  logic            err_pulse_reg;
  logic [7:0]      err_cnt_reg;
  logic [2*EW-1:0] entries;
  logic [EW-1:0]   entry_next, head;

  logic            legal, use_rs;
  logic [1:0]      dec_aluc;
  logic [SHW-1:0]  dec_b;
  logic            accept, push, pop, illegal;

  // Only the low SHW bits of rs matter as a shift amount.
  logic unused_rs;
  assign unused_rs = ^in_rs[WIDTH-1:SHW];

  always_comb begin
    legal    = 1'b1;
    use_rs   = 1'b0;
    dec_aluc = 2'b00;
    case (in_funct)
      6'b000000: dec_aluc = 2'b10;
      6'b000100: begin dec_aluc = 2'b10; use_rs = 1'b1; end
      6'b000010: dec_aluc = 2'b01;
      6'b000110: begin dec_aluc = 2'b01; use_rs = 1'b1; end
      6'b000011: dec_aluc = 2'b00;
      6'b000111: begin dec_aluc = 2'b00; use_rs = 1'b1; end
      default:   legal = 1'b0;
    endcase
  end

  assign dec_b      = use_rs ? in_rs[SHW-1:0] : in_shamt;
  assign entry_next = {in_rt, dec_b, dec_aluc, in_tag};

  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign accept    = in_valid & in_ready;
  assign push      = accept & legal;
  assign illegal   = accept & ~legal;
  assign pop       = out_valid & out_ready;

  // Storage slots are reset so the outputs read zero straight out of reset.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    logic [EW-1:0] slot_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        slot_reg <= '0;
      else if (push && (wr_ptr_reg == 1'(gi)))
        slot_reg <= entry_next;
    end
    assign entries[gi*EW +: EW] = slot_reg;
  end

  assign head = rd_ptr_reg ? entries[2*EW-1:EW] : entries[EW-1:0];
  assign {sh_a, sh_b, sh_aluc, sh_tag} = head;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg     <= 2'd0;
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      err_pulse_reg <= 1'b0;
      err_cnt_reg   <= 8'd0;
    end else begin
      count_reg     <= count_next;
      err_pulse_reg <= illegal;
      if (push)
        wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)
        rd_ptr_reg <= ~rd_ptr_reg;
      if (illegal && (err_cnt_reg != 8'hFF))
        err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign err_pulse = err_pulse_reg;
  assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Bench for shift_issue_stage: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_shift_issue_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [4:0]  b;
    logic [1:0]  aluc;
    logic [4:0]  tag;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_funct = '0;
  logic [31:0] in_rs = '0;
  logic [31:0] in_rt = '0;
  logic [4:0]  in_shamt = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] sh_a;
  logic [4:0]  sh_b;
  logic [1:0]  sh_aluc;
  logic [4:0]  sh_tag;
  logic        err_pulse;
  logic [7:0]  err_cnt;

  shift_issue_stage #(.WIDTH(32), .SHW(5), .TAGW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
    .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .sh_a(sh_a), .sh_b(sh_b), .sh_aluc(sh_aluc), .sh_tag(sh_tag),
    .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   passed = 0;
  op_t  mq[$];
  bit   m_err_pulse = 1'b0;
  int   m_err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
  endtask

  // Reference decode straight from the funct table.
  function automatic bit decode(input logic [5:0] f, input logic [31:0] rs,
                                input logic [31:0] rt, input logic [4:0] shamt,
                                input logic [4:0] tag, output op_t op);
    op.a = rt; op.tag = tag; op.b = shamt; op.aluc = 2'b00;
    case (f)
      6'd0:  op.aluc = 2'b10;
      6'd4:  begin op.aluc = 2'b10; op.b = rs[4:0]; end
      6'd2:  op.aluc = 2'b01;
      6'd6:  begin op.aluc = 2'b01; op.b = rs[4:0]; end
      6'd3:  op.aluc = 2'b00;
      6'd7:  begin op.aluc = 2'b00; op.b = rs[4:0]; end
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_err_pulse = 1'b0;
    m_err_cnt = 0;
  endtask

  task automatic model_update();
    op_t op;
    bit  lg, acc, pop;
    acc = in_valid && (mq.size() != 2);
    pop = (mq.size() != 0) && out_ready;
    lg  = decode(in_funct, in_rs, in_rt, in_shamt, in_tag, op);
    if (pop) void'(mq.pop_front());
    if (acc && lg) mq.push_back(op);
    m_err_pulse = acc && !lg;
    if (acc && !lg && m_err_cnt != 255) m_err_cnt++;
  endtask

  task automatic compare();
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(mq.size() != 2));
    chk("err_pulse", 32'(err_pulse), 32'(m_err_pulse));
    chk("err_cnt", 32'(err_cnt), 32'(m_err_cnt));
    if (mq.size() != 0) begin
      chk("sh_a", sh_a, mq[0].a);
      chk("sh_b", 32'(sh_b), 32'(mq[0].b));
      chk("sh_aluc", 32'(sh_aluc), 32'(mq[0].aluc));
      chk("sh_tag", 32'(sh_tag), 32'(mq[0].tag));
    end
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_update();
    #1;
  endtask

  task automatic set_op(input bit v, input logic [5:0] f, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [4:0] sa, input logic [4:0] tg);
    in_valid = v; in_funct = f; in_rs = rs; in_rt = rt; in_shamt = sa; in_tag = tg;
  endtask

  initial begin
    logic [5:0] legal_f [6];
    legal_f[0] = 6'd0; legal_f[1] = 6'd2; legal_f[2] = 6'd3;
    legal_f[3] = 6'd4; legal_f[4] = 6'd6; legal_f[5] = 6'd7;

    // Reset state
    step(); step();
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst sh_a", sh_a, 32'd0);
    chk("rst sh_b/aluc/tag", {20'd0, sh_b, sh_aluc, sh_tag}, 32'd0);
    chk("rst err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst release in_ready", 32'(in_ready), 32'd1);

    // sra, single op latency
    out_ready = 1'b1;
    set_op(1, 6'b000011, 32'h0, 32'hFFFF0000, 5'h0A, 5'd3);
    step();
    in_valid = 1'b0;
    chk("t1 out_valid", 32'(out_valid), 32'd1);
    chk("t1 sh_a", sh_a, 32'hFFFF0000);
    chk("t1 sh_b", 32'(sh_b), 32'h0A);
    chk("t1 sh_aluc", 32'(sh_aluc), 32'd0);
    chk("t1 sh_tag", 32'(sh_tag), 32'd3);
    step();

    // Illegal funct followed by sll
    set_op(1, 6'b100000, 32'h5, 32'h1234, 5'd9, 5'd1);
    step();
    set_op(1, 6'b000000, 32'h0, 32'h1, 5'd1, 5'd7);
    chk("t5 err_pulse", 32'(err_pulse), 32'd1);
    chk("t5 err_cnt", 32'(err_cnt), 32'd1);
    chk("t5 nothing queued", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    chk("t5 err_pulse drop", 32'(err_pulse), 32'd0);
    chk("t5 sll tag", 32'(sh_tag), 32'd7);
    step();

    // srlv then sllv, in order
    out_ready = 1'b0;
    set_op(1, 6'b000110, 32'h10, 32'hFFFF0000, 5'd0, 5'd4);
    step();
    set_op(1, 6'b000100, 32'h04, 32'hFFFF0000, 5'd0, 5'd5);
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    chk("t2 first b", 32'(sh_b), 32'h10);
    chk("t2 first aluc", 32'(sh_aluc), 32'd1);
    step();
    chk("t2 second b", 32'(sh_b), 32'h04);
    chk("t2 second aluc", 32'(sh_aluc), 32'd2);
    step();
    chk("t2 drained", 32'(out_valid), 32'd0);

    // Back-pressure with three ops
    out_ready = 1'b0;
    set_op(1, 6'b000010, 32'h0, 32'hA, 5'd1, 5'd11); step();
    set_op(1, 6'b000010, 32'h0, 32'hB, 5'd2, 5'd12); step();
    chk("t3 full in_ready", 32'(in_ready), 32'd0);
    chk("t3 head held", 32'(sh_tag), 32'd11);
    set_op(1, 6'b000010, 32'h0, 32'hC, 5'd3, 5'd13); step();
    chk("t3 head still", 32'(sh_tag), 32'd11);
    out_ready = 1'b1;
    step();
    chk("t3 second", 32'(sh_tag), 32'd12);
    chk("t3 in_ready back", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("t3 third", 32'(sh_tag), 32'd13);
    step();
    chk("t3 drained", 32'(out_valid), 32'd0);

    // count=1 with simultaneous accept and issue
    out_ready = 1'b0;
    set_op(1, 6'b000011, 32'h0, 32'h20, 5'd4, 5'd20); step();
    set_op(1, 6'b000111, 32'h3, 32'h21, 5'd0, 5'd21); out_ready = 1'b1; step();
    in_valid = 1'b0;
    chk("t4 valid", 32'(out_valid), 32'd1);
    chk("t4 new head", 32'(sh_tag), 32'd21);
    step();
    chk("t4 no duplicate", 32'(out_valid), 32'd0);

    // Reset while full
    out_ready = 1'b0;
    set_op(1, 6'b000000, 32'h0, 32'hDEAD, 5'd5, 5'd30); step();
    set_op(1, 6'b000000, 32'h0, 32'hBEEF, 5'd6, 5'd31); step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6 out_valid", 32'(out_valid), 32'd0);
    chk("t6 sh_a", sh_a, 32'd0);
    chk("t6 sh_b/aluc/tag", {20'd0, sh_b, sh_aluc, sh_tag}, 32'd0);
    step(); step();
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    chk("t6 in_ready", 32'(in_ready), 32'd1);
    chk("t6 no stale", 32'(out_valid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [5:0] f;
      int k;
      k = $urandom_range(0, 7);
      f = (k < 6) ? legal_f[k] : 6'($urandom);
      set_op(($urandom_range(0, 3) != 0), f, $urandom, $urandom,
             5'($urandom), 5'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    // Saturation of the illegal-op counter
    out_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      set_op(1, 6'b100000, $urandom, $urandom, 5'($urandom), 5'($urandom));
      step();
    end
    in_valid = 1'b0;
    chk("t5 err_cnt sat", 32'(err_cnt), 32'hFF);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
